tx_lane_align_seq: RTL and testbench

Transmit-side lane alignment sequencer for the 8:1 TX IOD lane. It drives the parallel word into the TX IOD serializer. On start it sends a fixed training pattern so the far-end RX bit-align engine can centre its delay line. It then emits a sync marker and switches to payload: either internal PRBS7, or user data under a valid/ready handshake. It retrains on a far-end alignment error and stops in an ERROR state after too many failed attempts.

---
 rtl/tx_lane_align_seq_pkg.sv | 22 ++
 rtl/tx_lane_align_seq_if.sv | 11 +
 rtl/prbs7_par8_gen.sv | 41 ++++
 rtl/tx_lane_align_seq.sv | 175 +++++++++++++++++
 tb/tb_tx_lane_align_seq.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_lane_align_seq_pkg.sv
// Shared types and constants for the TX lane alignment sequencer.
package tx_lane_align_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_TRAIN      = 3'd1,
        ST_WAIT_ALIGN = 3'd2,
        ST_SYNC       = 3'd3,
        ST_DATA       = 3'd4,
        ST_ERROR      = 3'd5
    } state_e;

    // PRBS7 x^7 + x^6 + 1: feedback taps are the two oldest state bits.
    localparam logic [6:0] PRBS7_SEED  = 7'h7F;
    localparam int         PRBS7_TAP_A = 6;
    localparam int         PRBS7_TAP_B = 5;

    localparam int WORD_CNT_W    = 16;
    localparam int RETRY_CNT_W   = 4;
    localparam int RETRAIN_CNT_W = 8;

endpackage

// File: rtl/tx_lane_align_seq_if.sv
// User payload stream into the sequencer (valid/ready, no skid).
interface tx_lane_align_seq_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/prbs7_par8_gen.sv
// PRBS7 generator producing 8 bits per cycle, MSB = oldest bit.
module prbs7_par8_gen
    import tx_lane_align_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic       en_i,
    output logic [7:0] data_o
);

    logic [6:0] state_q;
    logic [6:0] state_d;
    logic [6:0] walk;

    // Unroll eight serial steps: output the oldest bit, shift in the feedback.
    always_comb begin
        walk   = state_q;
        data_o = '0;
        for (int i = 7; i >= 0; i--) begin
            data_o[i] = walk[6];
            walk      = {walk[5:0], walk[PRBS7_TAP_A] ^ walk[PRBS7_TAP_B]};
        end
        state_d = state_q;
        if (load_i) begin
            state_d = PRBS7_SEED;
        end else if (en_i) begin
            state_d = walk;
        end
    end

    // Generator state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= PRBS7_SEED;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/tx_lane_align_seq.sv
// TX lane alignment sequencer: training, sync marker, then PRBS7 or user payload.
//
// state      | meaning
// IDLE       | waiting for start with PLL locked, sending IDLE_WORD
// TRAIN      | sending TRAIN_PATTERN for TRAIN_MIN_WORDS beats
// WAIT_ALIGN | sending TRAIN_PATTERN until far end reports done/error/timeout
// SYNC       | sending SYNC_WORD for SYNC_WORDS beats
// DATA       | link up, sending PRBS7 or user payload
// ERROR      | retry budget exhausted, sending IDLE_WORD until restart
module tx_lane_align_seq
    import tx_lane_align_pkg::*;
#(
    parameter int                DATA_W          = 8,
    parameter logic [DATA_W-1:0] TRAIN_PATTERN   = 8'h55,
    parameter logic [DATA_W-1:0] SYNC_WORD       = 8'hBC,
    parameter int                SYNC_WORDS      = 4,
    parameter logic [DATA_W-1:0] IDLE_WORD       = 8'h00,
    parameter int                TRAIN_MIN_WORDS = 256,
    parameter int                TIMEOUT_WORDS   = 4096,
    parameter int                MAX_RETRY       = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     pll_lock_i,
    input  logic                     start_i,
    input  logic                     align_done_i,
    input  logic                     align_err_i,
    input  logic                     mode_i,
    tx_lane_align_seq_if.slave       s_if,
    output logic [DATA_W-1:0]        txd_data_o,
    output logic [2:0]               state_o,
    output logic [RETRY_CNT_W-1:0]   retry_cnt_o,
    output logic [RETRAIN_CNT_W-1:0] retrain_cnt_o,
    output logic                     link_up_o,
    output logic                     error_o
);

    state_e                   state_q, state_d;
    logic [WORD_CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic [RETRY_CNT_W-1:0]   retry_q, retry_d, retry_inc;
    logic [RETRAIN_CNT_W-1:0] retrain_q, retrain_d;
    logic                     mode_q, mode_d;
    logic [DATA_W-1:0]        txd_q, txd_d;
    logic                     prbs_load;
    logic                     prbs_en;
    logic [7:0]               prbs_data;

    prbs7_par8_gen u_prbs (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (prbs_load),
        .en_i   (prbs_en),
        .data_o (prbs_data)
    );

    assign prbs_en = (state_q == ST_DATA) && !mode_q;

    // Next-state and counter updates; loss of PLL lock overrides every transition.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        retry_d    = retry_q;
        retrain_d  = retrain_q;
        mode_d     = mode_q;
        prbs_load  = 1'b0;
        retry_inc  = retry_q + 1'b1;
        case (state_q)
            ST_IDLE, ST_ERROR: begin
                if (start_i) begin
                    state_d    = ST_TRAIN;
                    word_cnt_d = '0;
                    retry_d    = '0;
                end
            end
            ST_TRAIN: begin
                if (word_cnt_q == WORD_CNT_W'(TRAIN_MIN_WORDS - 1)) begin
                    state_d    = ST_WAIT_ALIGN;
                    word_cnt_d = '0;
                end else begin
                    word_cnt_d = word_cnt_q + 1'b1;
                end
            end
            ST_WAIT_ALIGN: begin
                // An error wins over done in the same cycle.
                if (align_err_i || (!align_done_i &&
                        word_cnt_q == WORD_CNT_W'(TIMEOUT_WORDS - 1))) begin
                    retry_d    = retry_inc;
                    word_cnt_d = '0;
                    state_d    = (retry_inc == RETRY_CNT_W'(MAX_RETRY)) ? ST_ERROR : ST_TRAIN;
                end else if (align_done_i) begin
                    state_d    = ST_SYNC;
                    word_cnt_d = '0;
                end else begin
                    word_cnt_d = word_cnt_q + 1'b1;
                end
            end
            ST_SYNC: begin
                if (word_cnt_q == WORD_CNT_W'(SYNC_WORDS - 1)) begin
                    state_d    = ST_DATA;
                    word_cnt_d = '0;
                    mode_d     = mode_i;
                    prbs_load  = 1'b1;
                end else begin
                    word_cnt_d = word_cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (align_err_i) begin
                    state_d    = ST_TRAIN;
                    word_cnt_d = '0;
                    retry_d    = '0;
                    if (retrain_q != '1) begin
                        retrain_d = retrain_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (!pll_lock_i) begin
            state_d    = ST_IDLE;
            word_cnt_d = '0;
            retry_d    = retry_q;
            retrain_d  = retrain_q;
            mode_d     = mode_q;
            prbs_load  = 1'b0;
        end
    end

    // Output word selection from the current state; registered below.
    always_comb begin
        txd_d = IDLE_WORD;
        case (state_q)
            ST_TRAIN, ST_WAIT_ALIGN: txd_d = TRAIN_PATTERN;
            ST_SYNC:                 txd_d = SYNC_WORD;
            ST_DATA: begin
                if (!mode_q) begin
                    txd_d = prbs_data;
                end else if (s_if.s_valid) begin
                    txd_d = s_if.s_data;
                end
            end
            default:                 txd_d = IDLE_WORD;
        endcase
    end

    // State, counters, latched mode and output word registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= '0;
            retry_q    <= '0;
            retrain_q  <= '0;
            mode_q     <= 1'b0;
            txd_q      <= IDLE_WORD;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            retry_q    <= retry_d;
            retrain_q  <= retrain_d;
            mode_q     <= mode_d;
            txd_q      <= txd_d;
        end
    end

    assign s_if.s_ready  = (state_q == ST_DATA) && mode_q;
    assign txd_data_o    = txd_q;
    assign state_o       = state_q;
    assign retry_cnt_o   = retry_q;
    assign retrain_cnt_o = retrain_q;
    assign link_up_o     = (state_q == ST_DATA);
    assign error_o       = (state_q == ST_ERROR);

endmodule

// File: tb/tb_tx_lane_align_seq.sv
// Directed bench for tx_lane_align_seq: default instance plus a short-timing
// instance used only to reach retrain counter saturation quickly.
module tb_tx_lane_align_seq;

    logic       clk;
    logic       rst;
    logic       pll_lock;
    logic       start;
    logic       align_done;
    logic       align_err;
    logic       mode;
    logic [7:0] txd;
    logic [2:0] state;
    logic [3:0] retry_cnt;
    logic [7:0] retrain_cnt;
    logic       link_up;
    logic       error;

    logic       f_start;
    logic       f_align_done;
    logic       f_align_err;
    logic [7:0] f_txd;
    logic [2:0] f_state;
    logic [3:0] f_retry_cnt;
    logic [7:0] f_retrain_cnt;
    logic       f_link_up;
    logic       f_error;

    int checks   = 0;
    int failures = 0;

    tx_lane_align_seq_if m_if ();
    tx_lane_align_seq_if f_if ();

    tx_lane_align_seq dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pll_lock_i    (pll_lock),
        .start_i       (start),
        .align_done_i  (align_done),
        .align_err_i   (align_err),
        .mode_i        (mode),
        .s_if          (m_if),
        .txd_data_o    (txd),
        .state_o       (state),
        .retry_cnt_o   (retry_cnt),
        .retrain_cnt_o (retrain_cnt),
        .link_up_o     (link_up),
        .error_o       (error)
    );

    tx_lane_align_seq #(
        .SYNC_WORDS      (1),
        .TRAIN_MIN_WORDS (2),
        .TIMEOUT_WORDS   (8)
    ) dut_fast (
        .clk_i         (clk),
        .rst_i         (rst),
        .pll_lock_i    (pll_lock),
        .start_i       (f_start),
        .align_done_i  (f_align_done),
        .align_err_i   (f_align_err),
        .mode_i        (1'b0),
        .s_if          (f_if),
        .txd_data_o    (f_txd),
        .state_o       (f_state),
        .retry_cnt_o   (f_retry_cnt),
        .retrain_cnt_o (f_retrain_cnt),
        .link_up_o     (f_link_up),
        .error_o       (f_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic [7:0] exp_txd;
    } user_vec_t;

    user_vec_t uvec[10];
    bit        prbs_bits[0:255];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int limit, input string name);
        int n;
        n = 0;
        while (state !== s && n < limit) begin
            tick();
            n++;
        end
        check(name, state, s);
    endtask

    task automatic go_to_data(input string name);
        wait_state(3'd2, 400, {name, "_wait"});
        align_done = 1'b1;
        tick();
        align_done = 1'b0;
        wait_state(3'd4, 10, {name, "_data"});
    endtask

    function automatic logic [7:0] prbs_word(input int k);
        logic [7:0] w;
        w = '0;
        for (int j = 0; j < 8; j++) w = {w[6:0], prbs_bits[8*k + j]};
        return w;
    endfunction

    initial begin
        int n;
        int bad;
        int f_to;

        // Serial PRBS7 reference: seven ones, then b[n] = b[n-7] ^ b[n-6].
        for (int i = 0; i < 256; i++)
            prbs_bits[i] = (i < 7) ? 1'b1 : (prbs_bits[i-7] ^ prbs_bits[i-6]);

        uvec[0] = '{1'b1, 8'h01, 8'h01};
        uvec[1] = '{1'b0, 8'h02, 8'h00};
        uvec[2] = '{1'b1, 8'h02, 8'h02};
        uvec[3] = '{1'b1, 8'h03, 8'h03};
        uvec[4] = '{1'b0, 8'hAA, 8'h00};
        uvec[5] = '{1'b0, 8'h04, 8'h00};
        uvec[6] = '{1'b1, 8'h04, 8'h04};
        uvec[7] = '{1'b1, 8'h05, 8'h05};
        uvec[8] = '{1'b0, 8'hFF, 8'h00};
        uvec[9] = '{1'b1, 8'h06, 8'h06};

        rst = 1'b1; pll_lock = 1'b1; start = 1'b0; align_done = 1'b0;
        align_err = 1'b0; mode = 1'b0;
        m_if.s_data = 8'h00; m_if.s_valid = 1'b0;
        f_start = 1'b0; f_align_done = 1'b1; f_align_err = 1'b0;
        f_if.s_data = 8'h00; f_if.s_valid = 1'b0;
        repeat (3) tick();

        check("rst_state", state, 3'd0);
        check("rst_txd", txd, 8'h00);
        check("rst_ready", m_if.s_ready, 1'b0);
        check("rst_link", link_up, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_retry", retry_cnt, 4'd0);
        check("rst_retrain", retrain_cnt, 8'd0);

        // Training, sync, PRBS payload.
        rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_train", state, 3'd1);
        check("start_txd_idle", txd, 8'h00);
        n = 0; bad = 0;
        while (state == 3'd1 && n < 400) begin
            tick();
            n++;
            if (txd !== 8'h55) bad++;
        end
        check("train_len", n, 256);
        check("train_pattern_bad", bad, 0);
        check("train_to_wait", state, 3'd2);
        repeat (10) tick();
        check("wait_hold", state, 3'd2);
        check("wait_txd", txd, 8'h55);
        align_done = 1'b1;
        tick();
        align_done = 1'b0;
        check("wait_to_sync", state, 3'd3);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (txd !== 8'hBC) bad++;
        end
        check("sync_words_bad", bad, 0);
        check("sync_to_data", state, 3'd4);
        check("data_link", link_up, 1'b1);
        check("prbs_ready", m_if.s_ready, 1'b0);
        tick();
        check("prbs_first", txd, 8'hFE);
        for (int k = 1; k < 16; k++) begin
            tick();
            check($sformatf("prbs_word_%0d", k), txd, prbs_word(k));
        end

        // Retrain from PRBS payload.
        align_err = 1'b1;
        tick();
        align_err = 1'b0;
        check("retrain1_state", state, 3'd1);
        check("retrain1_cnt", retrain_cnt, 8'd1);
        check("retrain1_retry", retry_cnt, 4'd0);
        check("retrain1_link", link_up, 1'b0);

        // User payload.
        mode = 1'b1;
        go_to_data("user");
        for (int i = 0; i < 10; i++) begin
            m_if.s_valid = uvec[i].valid;
            m_if.s_data  = uvec[i].data;
            #1;
            check($sformatf("user_ready_%0d", i), m_if.s_ready, 1'b1);
            tick();
            check($sformatf("user_txd_%0d", i), txd, uvec[i].exp_txd);
        end
        m_if.s_valid = 1'b1;
        align_err = 1'b1;
        tick();
        align_err = 1'b0;
        m_if.s_valid = 1'b0;
        check("retrain2_state", state, 3'd1);
        check("retrain2_ready", m_if.s_ready, 1'b0);
        check("retrain2_cnt", retrain_cnt, 8'd2);

        // Loss of lock in SYNC.
        wait_state(3'd2, 400, "lock_sync_wait");
        align_done = 1'b1;
        tick();
        align_done = 1'b0;
        check("lock_sync_in_sync", state, 3'd3);
        pll_lock = 1'b0;
        tick();
        check("lock_sync_idle", state, 3'd0);
        tick();
        check("lock_sync_txd", txd, 8'h00);

        // Loss of lock in DATA.
        pll_lock = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        go_to_data("lock_data");
        pll_lock = 1'b0;
        tick();
        check("lock_data_idle", state, 3'd0);
        check("lock_data_link", link_up, 1'b0);
        tick();
        check("lock_data_txd", txd, 8'h00);

        // Reset in the middle of TRAIN.
        pll_lock = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (50) tick();
        check("midtrain_state", state, 3'd1);
        rst = 1'b1;
        tick();
        check("midrst_state", state, 3'd0);
        check("midrst_txd", txd, 8'h00);
        check("midrst_retrain", retrain_cnt, 8'd0);
        check("midrst_ready", m_if.s_ready, 1'b0);
        check("midrst_link", link_up, 1'b0);
        rst = 1'b0;
        tick();

        // Error and done together, then two timeouts to ERROR.
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_state(3'd2, 400, "both_wait");
        align_err = 1'b1;
        align_done = 1'b1;
        tick();
        align_err = 1'b0;
        align_done = 1'b0;
        check("both_retry_state", state, 3'd1);
        check("both_retry_cnt", retry_cnt, 4'd1);
        wait_state(3'd2, 400, "to1_wait");
        n = 0;
        while (state == 3'd2 && n < 5000) begin
            tick();
            n++;
        end
        check("timeout_len", n, 4096);
        check("timeout1_state", state, 3'd1);
        check("timeout1_retry", retry_cnt, 4'd2);
        wait_state(3'd2, 400, "to2_wait");
        n = 0;
        while (state == 3'd2 && n < 5000) begin
            tick();
            n++;
        end
        check("timeout2_len", n, 4096);
        check("error_state", state, 3'd5);
        check("error_flag", error, 1'b1);
        check("error_retry", retry_cnt, 4'd3);
        tick();
        check("error_txd", txd, 8'h00);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_state", state, 3'd1);
        check("restart_retry", retry_cnt, 4'd0);
        check("restart_error", error, 1'b0);

        // Retrain counter saturation on the short-timing instance.
        f_start = 1'b1;
        tick();
        f_start = 1'b0;
        f_to = 0;
        for (int r = 0; r < 300; r++) begin
            n = 0;
            while (f_state !== 3'd4 && n < 50) begin
                tick();
                n++;
            end
            if (f_state !== 3'd4) f_to++;
            f_align_err = 1'b1;
            tick();
            f_align_err = 1'b0;
            if (r == 0)   check("fast_retrain_1", f_retrain_cnt, 8'd1);
            if (r == 253) check("fast_retrain_254", f_retrain_cnt, 8'd254);
            if (r == 254) check("fast_retrain_255", f_retrain_cnt, 8'd255);
        end
        check("fast_data_timeouts", f_to, 0);
        check("fast_retrain_sat", f_retrain_cnt, 8'd255);
        check("fast_state", f_state, 3'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
